// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, issue/writeback strobes and debug view.
// The master side drives indices and strobes; the slave side returns data and hazards.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRP-1:0][AW-1:0]     rs_index;
    logic [NRP-1:0][XLEN-1:0]   rs_out;
    logic [NRP-1:0]             rs_busy;
    logic                       iss_valid;
    logic [AW-1:0]              iss_rd;
    logic                       wb_valid;
    logic [AW-1:0]              wb_rd;
    logic [XLEN-1:0]            wb_data;
    logic                       stall;
    logic [NREGS-1:0][XLEN-1:0] debug_registers;

    modport master (
        output rs_index, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        input  rs_out, rs_busy, stall, debug_registers
    );

    modport slave (
        input  rs_index, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        output rs_out, rs_busy, stall, debug_registers
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy (scoreboard) bits and NRP combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;

    // Issue is applied after writeback so a same-index collision leaves busy set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (bus.wb_valid && bus.wb_rd != '0) begin
            regs_d[bus.wb_rd] = bus.wb_data;
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_rd != '0) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Index 0 is decoded explicitly so x0 reads as zero even before any reset.
    always_comb begin
        bus.rs_out  = '0;
        bus.rs_busy = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            if (!rst && bus.rs_index[p] != '0) begin
                bus.rs_out[p]  = regs_q[bus.rs_index[p]];
                bus.rs_busy[p] = busy_q[bus.rs_index[p]];
`ifdef REGFILE_BYPASS_EN
                if (bus.wb_valid && bus.wb_rd == bus.rs_index[p]) begin
                    bus.rs_out[p]  = bus.wb_data;
                    bus.rs_busy[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.stall = |bus.rs_busy;

    always_comb begin
        bus.debug_registers    = regs_q;
        bus.debug_registers[0] = '0;
        if (rst) begin
            bus.debug_registers = '0;
        end
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, number of independent read ports (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rs_index  input  NRP x AW  read-port register indices.
REQ-007 SHALL have port rs_out  output  NRP x XLEN  read-port data.
REQ-008 SHALL have port rs_busy  output  NRP  read-port source has a pending write (hazard).
REQ-009 SHALL have port iss_valid  input  1  an instruction targeting iss_rd is issued this cycle.
REQ-010 SHALL have port iss_rd  input  AW  destination of the issuing instruction.
REQ-011 SHALL have port wb_valid  input  1  writeback valid this cycle.
REQ-012 SHALL have port wb_rd  input  AW  writeback destination index.
REQ-013 SHALL have port wb_data  input  XLEN  writeback data.
REQ-014 SHALL have port stall  output  1  OR of rs_busy over all NRP ports.
REQ-015 SHALL have port debug_registers  output  NREGS x XLEN  live copy of all register contents.

Function
REQ-016 SHALL hold NREGS registers plus one busy bit per register; index 0 reads as 0, is never written and is never busy.
REQ-017 SHALL, on a rising edge with wb_valid=1 and wb_rd!=0, store wb_data in regs[wb_rd] and clear busy[wb_rd].
REQ-018 SHALL, on a rising edge with iss_valid=1 and iss_rd!=0, set busy[iss_rd].
REQ-019 SHALL, when issue and writeback hit the same nonzero index in one cycle, store wb_data and leave busy set (issue wins).
REQ-020 SHALL drive rs_out[p] combinationally: 0 if rs_index[p]=0, else regs[rs_index[p]] (subject to REQ-030).
REQ-021 SHALL drive rs_busy[p] combinationally = busy[rs_index[p]], subject to REQ-030/REQ-031.
REQ-022 SHALL ignore iss_rd/wb_rd/wb_data when the matching valid is 0; no register or busy bit changes.
REQ-023 SHALL give identical results on all read ports addressing the same index in the same cycle.
REQ-024 SHALL tolerate writeback to a non-busy register (store data, busy stays 0) without error.
REQ-025 SHALL drive debug_registers from stored state only (no bypass), entry 0 always 0.

Reset
REQ-026 SHALL, on a rising edge with rst=1, clear every register to 0 and every busy bit to 0, overriding any simultaneous issue or writeback.
REQ-027 SHALL, during and after reset, present rs_out=0, rs_busy=0, stall=0, debug_registers all 0.
REQ-028 SHALL, when reset asserts mid-sequence (pending busy bits), discard all pending hazards; a later wb_valid to that index writes normally.
REQ-029 SHALL require no reset for correct x0 behaviour; x0 is constant 0 at all times.

Configuration
REQ-030 SHALL, with macro REGFILE_BYPASS_EN defined, forward wb_data to rs_out[p] and force rs_busy[p]=0 when wb_valid=1 and wb_rd=rs_index[p]!=0 in the same cycle (zero-latency read-after-write).
REQ-031 SHALL, without REGFILE_BYPASS_EN, return the stored value and keep rs_busy[p]=busy[rs_index[p]] until the edge that completes the write (one-cycle read-after-write latency).

Verification
REQ-032 SHALL cover: rst=1 one cycle after filling regs -> all rs_out=0, stall=0, debug_registers all 0.
REQ-033 SHALL cover: wb_valid=1, wb_rd=0, wb_data=32'hDEADBEEF -> rs_out for index 0 stays 0; debug_registers[0]=0.
REQ-034 SHALL cover: issue rd=5, next cycle rs_index[0]=5 -> rs_busy[0]=1, stall=1; wb rd=5 data=32'h1234 -> bypass on: same cycle rs_out[0]=32'h1234, busy 0; bypass off: next cycle.
REQ-035 SHALL cover: same cycle issue rd=7 and wb rd=7 data=32'h55 -> regs[7]=32'h55, busy[7]=1.
REQ-036 SHALL cover: issue rd=3, rst=1 next edge, then wb rd=3 data=32'hA -> busy[3]=0 after reset, regs[3]=32'hA.
REQ-037 SHALL cover: NRP=3, all ports rs_index=9 with regs[9]=32'hCAFE -> all three rs_out=32'hCAFE.
